wb_sequencer: RTL
=================

WB_SEQUENCER -- requirements
Module: wb_sequencer

Interface
REQ-001 Parameter: RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 Port: clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high; sampled on the rising edge of clock.
REQ-004 Port: exec  input  1  single-cycle start/resume pulse.
REQ-005 Port: op1  input  2  instruction major class: 00 LD, 01 ST, 10 immediate/branch, 11 arithmetic.
REQ-006 Port: op2  input  3  sub-op when op1=10: 000 LI, 100 B, 111 conditional branch.
REQ-007 Port: opcode  input  4  arithmetic sub-op when op1=11.
REQ-008 Port: alu_out  input  16  ALU result.
REQ-009 Port: alu_S, alu_Z, alu_C, alu_V, alu_HLT  input  1 each  ALU flag and halt outputs.
REQ-010 Port: pc  output  16  current program counter.
REQ-011 Port: pc_plus1  output  16  pc+1, combinational, modulo 2^16.
REQ-012 Port: S_flag, Z_flag, C_flag, V_flag  output  1 each  registered flags; drive the ALU S_in/Z_in/C_in/V_in.
REQ-013 Port: phase  output  5  one-hot P1..P5 as bits 0..4; 5'b00000 in IDLE.
REQ-014 Port: rf_we  output  1  register-file write strobe.
REQ-015 Port: mem_we  output  1  data-memory write strobe.
REQ-016 Port: halted  output  1  high while stopped.

Function
REQ-017 The FSM SHALL have states IDLE, P1, P2, P3, P4, P5; P1->P2->P3->P4->P5->P1, one clock each, while running.
REQ-018 In IDLE, an exec pulse SHALL move the FSM to P1 on the next edge; other inputs SHALL be ignored.
REQ-019 At the P3->P4 edge with op1=11, S/Z/C/V_flag SHALL load alu_S/Z/C/V; for other op1 values the flags SHALL hold.
REQ-020 At the P3->P4 edge with op1=11, opcode=4'b1111 and alu_HLT=1, the FSM SHALL go to IDLE, set halted=1, and leave pc unchanged.
REQ-021 mem_we SHALL be 1 during P4 iff op1=01, and 0 otherwise.
REQ-022 rf_we SHALL be 1 during P5 iff one of the following holds: op1=00; op1=10 with op2=000; op1=11 with opcode in {0,1,2,3,4,6,8,9,10,11}. It SHALL be 0 otherwise.
REQ-023 At the P5->P1 edge, pc SHALL load alu_out if op1=10 and op2 is 100 or 111; otherwise pc SHALL load pc_plus1.
REQ-024 A conditional branch SHALL take no condition decision here; the ALU supplies pc+1 or the target in alu_out.
REQ-025 pc SHALL wrap: 16'hFFFF+1 = 16'h0000.
REQ-026 An exec pulse while halted=1 SHALL clear halted, set pc to pc_plus1, and enter P1 on the next edge.
REQ-027 exec while running (P1..P5) SHALL be ignored.
REQ-028 phase, rf_we and mem_we SHALL be decoded from the registered state only, so they are glitch-free relative to clock.

Reset
REQ-029 When reset=1 at an edge, the block SHALL set state=IDLE, pc=RESET_PC, all flags=0 and halted=0, regardless of state or exec.
REQ-030 During reset and in IDLE, phase, rf_we and mem_we SHALL be 0.
REQ-031 Reset asserted mid-instruction (any of P1..P5) SHALL abort the instruction with no pc or flag update on that edge.

Verification
REQ-032 Reset, exec pulse, op1=11/opcode=0 repeated, alu_out arbitrary -> phase steps 00001,00010,00100,01000,10000; rf_we high in P5 only; pc 0->1->2.
REQ-033 op1=11, alu_S=1, alu_Z=0, alu_C=1, alu_V=1 at P3 -> flags read 1,0,1,1 from P4; flags unchanged across a following op1=10/op2=000 instruction.
REQ-034 op1=10, op2=100, alu_out=16'h0040 at P5 -> pc=16'h0040 at next P1; rf_we=0.
REQ-035 op1=11, opcode=15, alu_HLT=1 at pc=16'h0007 -> halted=1, phase=0, pc=16'h0007; exec -> halted=0, pc=16'h0008, P1.
REQ-036 op1=01 -> mem_we=1 in P4 only; rf_we=0; reset asserted during P3 -> next cycle IDLE, pc=RESET_PC, flags 0.
REQ-037 pc=16'hFFFF with a non-branch instruction -> pc=16'h0000 after P5.

Source files
------------

// File: rtl/wb_sequencer.sv
// wb_sequencer: five-phase instruction sequencer for a small 16-bit CPU.
//
// One instruction takes five clocks, P1..P5. The block holds the program
// counter, the four condition flags and the halt status. It produces the
// phase strobes and the register-file and data-memory write strobes.
//
// Ports
//   clock                      system clock; all state changes on its rising edge
//   reset                      synchronous, active-high
//   exec                       start/resume pulse, used only in IDLE
//   op1[1:0]                   major class: 00 LD, 01 ST, 10 imm/branch, 11 arith
//   op2[2:0]                   sub-op for op1=10: 000 LI, 100 B, 111 cond. branch
//   opcode[3:0]                arithmetic sub-op for op1=11
//   alu_out[15:0]              ALU result; this is also the branch target
//   alu_S/Z/C/V, alu_HLT       ALU flag and halt outputs
//   pc[15:0], pc_plus1[15:0]   program counter and pc+1 (wraps modulo 2^16)
//   S/Z/C/V_flag               registered flags; these feed back to the ALU
//   phase[4:0]                 one-hot P1..P5 on bits 0..4; all zero in IDLE
//   rf_we, mem_we              write strobes, asserted in P5 and P4
//   halted                     high while stopped by a halt instruction
module wb_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        exec,
  input  logic [1:0]  op1,
  input  logic [2:0]  op2,
  input  logic [3:0]  opcode,
  input  logic [15:0] alu_out,
  input  logic        alu_S,
  input  logic        alu_Z,
  input  logic        alu_C,
  input  logic        alu_V,
  input  logic        alu_HLT,
  output logic [15:0] pc,
  output logic [15:0] pc_plus1,
  output logic        S_flag,
  output logic        Z_flag,
  output logic        C_flag,
  output logic        V_flag,
  output logic [4:0]  phase,
  output logic        rf_we,
  output logic        mem_we,
  output logic        halted
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_P1   = 3'd1,
    ST_P2   = 3'd2,
    ST_P3   = 3'd3,
    ST_P4   = 3'd4,
    ST_P5   = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [3:0]  flags_q, flags_d;   // {S, Z, C, V}
  logic        halted_q, halted_d;

  // Instruction decode. The branch condition is resolved by the ALU, so
  // both branch kinds load alu_out here.
  logic is_arith, is_branch, is_halt, rf_write;

  assign is_arith  = (op1 == 2'b11);
  assign is_branch = (op1 == 2'b10) && ((op2 == 3'b100) || (op2 == 3'b111));
  assign is_halt   = is_arith && (opcode == 4'b1111) && alu_HLT;
  assign rf_write  = (op1 == 2'b00)
                   || ((op1 == 2'b10) && (op2 == 3'b000))
                   || (is_arith && (opcode inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
                                                   4'd6, 4'd8, 4'd9, 4'd10, 4'd11}));

  assign pc_plus1 = pc_q + 16'd1;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    flags_d  = flags_q;
    halted_d = halted_q;
    phase    = 5'b00000;
    rf_we    = 1'b0;
    mem_we   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (exec) begin
          state_d = ST_P1;
          // Resuming after a halt skips past the halt instruction.
          if (halted_q) begin
            halted_d = 1'b0;
            pc_d     = pc_plus1;
          end
        end
      end
      ST_P1: begin
        phase   = 5'b00001;
        state_d = ST_P2;
      end
      ST_P2: begin
        phase   = 5'b00010;
        state_d = ST_P3;
      end
      ST_P3: begin
        phase = 5'b00100;
        if (is_arith) begin
          flags_d = {alu_S, alu_Z, alu_C, alu_V};
        end
        // A halt leaves pc on the halt instruction itself.
        if (is_halt) begin
          state_d  = ST_IDLE;
          halted_d = 1'b1;
        end else begin
          state_d = ST_P4;
        end
      end
      ST_P4: begin
        phase   = 5'b01000;
        mem_we  = (op1 == 2'b01);
        state_d = ST_P5;
      end
      ST_P5: begin
        phase   = 5'b10000;
        rf_we   = rf_write;
        pc_d    = is_branch ? alu_out : pc_plus1;
        state_d = ST_P1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      flags_q  <= 4'b0000;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      flags_q  <= flags_d;
      halted_q <= halted_d;
    end
  end

  assign pc     = pc_q;
  assign S_flag = flags_q[3];
  assign Z_flag = flags_q[2];
  assign C_flag = flags_q[1];
  assign V_flag = flags_q[0];
  assign halted = halted_q;

endmodule
